bp_ctr_update: RTL

Branch-predictor counter update unit. Sits directly upstream of the branch-predictor counter RAM's write port. Accepts up to two resolved-branch updates per cycle from commit, queues them, and drains one per cycle as a saturating-counter read-modify-write into the RAM. Same-index back-to-back updates are forwarded so the second update does not overwrite the first with a stale counter.

---
 rtl/bp_ctr_update.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bp_ctr_update.sv
// Branch-predictor counter update unit.
// Queues up to two resolved-branch updates per cycle and drains one per cycle
// as a saturating read-modify-write into the counter RAM write port. The last
// written {index, data} is kept so a back-to-back update to the same index
// builds on the freshly written counter instead of its stale prediction-time copy.
//
// Handshake: lane k is accepted on a cycle where updk_valid_i && upd_ready_o.
// upd_ready_o depends only on registered occupancy. A valid lane presented
// while upd_ready_o is low is dropped and changes no state.
module bp_ctr_update #(
    parameter int DEPTH     = 4,
    parameter int INDEX     = 6,
    parameter int CNT_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   upd0_valid_i,
    input  logic [INDEX-1:0]       upd0_index_i,
    input  logic                   upd0_taken_i,
    input  logic [CNT_WIDTH-1:0]   upd0_ctr_i,
    input  logic                   upd1_valid_i,
    input  logic [INDEX-1:0]       upd1_index_i,
    input  logic                   upd1_taken_i,
    input  logic [CNT_WIDTH-1:0]   upd1_ctr_i,
    output logic                   upd_ready_o,
    output logic                   we0_o,
    output logic [INDEX-1:0]       addr0wr_o,
    output logic [CNT_WIDTH-1:0]   data0wr_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CNT_WIDTH-1:0] CTR_MAX = '1;

    logic [INDEX-1:0]     q_index [DEPTH];
    logic                 q_taken [DEPTH];
    logic [CNT_WIDTH-1:0] q_ctr   [DEPTH];

    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        wr_ptr1;
    logic [CW-1:0]        count;

    logic                 lw_valid;
    logic [INDEX-1:0]     lw_index;
    logic [CNT_WIDTH-1:0] lw_data;

    logic                 acc0;
    logic                 acc1;
    logic                 deq;
    logic [INDEX-1:0]     h_index;
    logic                 h_taken;
    logic [CNT_WIDTH-1:0] h_ctr;
    logic [CNT_WIDTH-1:0] base;
    logic [CNT_WIDTH-1:0] nxt;

    assign upd_ready_o = (count <= CW'(DEPTH - 2));
    assign acc0        = upd0_valid_i && upd_ready_o;
    assign acc1        = upd1_valid_i && upd_ready_o;
    assign deq         = (count != '0);
    // Lane 1 lands right behind lane 0 when both are accepted, else in lane 0's slot.
    assign wr_ptr1     = wr_ptr + PW'(acc0);

    assign h_index = q_index[rd_ptr];
    assign h_taken = q_taken[rd_ptr];
    assign h_ctr   = q_ctr[rd_ptr];

    // Pick the forwarded counter when the head hits the last written index, then saturate.
    always_comb begin
        base = h_ctr;
        nxt  = '0;
        if (lw_valid && (lw_index == h_index)) begin
            base = lw_data;
        end
        if (h_taken) begin
            nxt = (base == CTR_MAX) ? CTR_MAX : base + 1'b1;
        end else begin
            nxt = (base == '0) ? '0 : base - 1'b1;
        end
    end

    // Write port is driven straight from the head; all zero while the queue is empty.
    always_comb begin
        we0_o     = deq;
        addr0wr_o = '0;
        data0wr_o = '0;
        if (deq) begin
            addr0wr_o = h_index;
            data0wr_o = nxt;
        end
    end

    assign count_o = count;

    // Queue storage: accepted lanes are written in lane order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_index[i] <= '0;
                q_taken[i] <= 1'b0;
                q_ctr[i]   <= '0;
            end
        end else begin
            if (acc0) begin
                q_index[wr_ptr] <= upd0_index_i;
                q_taken[wr_ptr] <= upd0_taken_i;
                q_ctr[wr_ptr]   <= upd0_ctr_i;
            end
            if (acc1) begin
                q_index[wr_ptr1] <= upd1_index_i;
                q_taken[wr_ptr1] <= upd1_taken_i;
                q_ctr[wr_ptr1]   <= upd1_ctr_i;
            end
        end
    end

    // Pointers and occupancy; enqueue and dequeue may happen in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(acc0) + PW'(acc1);
            rd_ptr <= rd_ptr + PW'(deq);
            count  <= count + CW'(acc0) + CW'(acc1) - CW'(deq);
        end
    end

    // Remember the most recent RAM write for same-index forwarding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lw_valid <= 1'b0;
            lw_index <= '0;
            lw_data  <= '0;
        end else if (deq) begin
            lw_valid <= 1'b1;
            lw_index <= h_index;
            lw_data  <= nxt;
        end
    end

endmodule
